// File: rtl/sc_trace_capture.sv
// rtl/sc_trace_capture.sv - trigger-qualified circular trace capture with valid/ready drain
module sc_trace_capture #(
    parameter int NCH    = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  probe_en,
    input  logic [NCH*DATA_W-1:0] probe,
    input  logic [DATA_W-1:0]     trig_val,
    input  logic [DATA_W-1:0]     trig_mask,
    input  logic [AW-1:0]         post_cnt,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [NCH*DATA_W-1:0] rd_data,
    output logic                  rd_last,
    output logic                  triggered,
    output logic                  busy,
    output logic [31:0]           cyc_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    state_t                state;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         remain;
    logic [AW:0]           fill;
    logic [AW:0]           rd_cnt;
    logic [NCH*DATA_W-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  hit;
    logic [AW:0]           fill_nxt;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [31:0]           cyc_inc;

    always_comb begin
        wr_en      = ((state == S_ARMED) || (state == S_POST)) && probe_en;
        hit        = ((probe[DATA_W-1:0] ^ trig_val) & trig_mask) == '0;
        fill_nxt   = (wr_en && (fill != FULL)) ? fill + 1'b1 : fill;
        wr_ptr_nxt = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        cyc_inc    = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;
    end

    assign busy     = (state != S_IDLE);
    assign rd_valid = (state == S_DONE) && (rd_cnt != '0);
    assign rd_last  = rd_valid && (rd_cnt == ONE);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // RAM is deliberately left without reset; fill/rd_cnt gate every read.
    always_ff @(posedge CLK) begin
        if (wr_en && !abort)
            mem[wr_ptr] <= probe;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remain    <= '0;
            fill      <= '0;
            rd_cnt    <= '0;
            triggered <= 1'b0;
            cyc_cnt   <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            fill      <= '0;
            rd_cnt    <= '0;
            triggered <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state     <= S_ARMED;
                        wr_ptr    <= '0;
                        fill      <= '0;
                        triggered <= 1'b0;
                        cyc_cnt   <= '0;
                        remain    <= post_cnt;
                    end
                end
                S_ARMED: begin
                    cyc_cnt <= cyc_inc;
                    if (wr_en) begin
                        wr_ptr <= wr_ptr_nxt;
                        fill   <= fill_nxt;
                        if (hit) begin
                            triggered <= 1'b1;
                            if (remain == '0) begin
                                state  <= S_DONE;
                                rd_ptr <= (fill_nxt == FULL) ? wr_ptr_nxt : '0;
                                rd_cnt <= fill_nxt;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    cyc_cnt <= cyc_inc;
                    if (wr_en) begin
                        wr_ptr <= wr_ptr_nxt;
                        fill   <= fill_nxt;
                        remain <= remain - 1'b1;
                        // Oldest entry sits at the write pointer once the ring has wrapped.
                        if (remain == ONE[AW-1:0]) begin
                            state  <= S_DONE;
                            rd_ptr <= (fill_nxt == FULL) ? wr_ptr_nxt : '0;
                            rd_cnt <= fill_nxt;
                        end
                    end
                end
                S_DONE: begin
                    cyc_cnt <= cyc_inc;
                    if (rd_valid && rd_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rd_cnt <= rd_cnt - 1'b1;
                        if (rd_cnt == ONE)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_trace_capture.sv
// tb/tb_sc_trace_capture.sv - directed self-checking bench for sc_trace_capture
module tb_sc_trace_capture;
    logic         CLK = 1'b0;
    logic         rst;
    logic         arm, abort, probe_en, rd_ready;
    logic [127:0] probe;
    logic [31:0]  trig_val, trig_mask;
    logic [3:0]   post_cnt;
    logic         rd_valid, rd_last, triggered, busy;
    logic [127:0] rd_data;
    logic [31:0]  cyc_cnt;

    int total = 0;
    int bad   = 0;

    logic [127:0] got_q[$];
    bit           last_q[$];
    int           held_diff;
    bit           drain_ok;

    sc_trace_capture #(.NCH(4), .DATA_W(32), .DEPTH(16)) dut (
        .CLK(CLK), .rst(rst), .arm(arm), .abort(abort), .probe_en(probe_en),
        .probe(probe), .trig_val(trig_val), .trig_mask(trig_mask), .post_cnt(post_cnt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .triggered(triggered), .busy(busy), .cyc_cnt(cyc_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [127:0] pat(input int i);
        logic [31:0] v;
        v = i;
        return {32'hA500_0000 | v, v * 32'd3, ~v, v};
    endfunction

    task automatic start(input logic [31:0] tv, input logic [31:0] tm, input logic [3:0] pc);
        @(negedge CLK);
        arm = 1'b1; trig_val = tv; trig_mask = tm; post_cnt = pc;
        @(negedge CLK);
        arm = 1'b0;
    endtask

    task automatic feed(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            probe = pat(i); probe_en = 1'b1;
            @(negedge CLK);
        end
        probe_en = 1'b0;
    endtask

    task automatic drain(input logic [3:0] rdy_pat);
        logic [127:0] held;
        bit stalled;
        got_q.delete(); last_q.delete();
        held_diff = 0; drain_ok = 0; stalled = 0; held = '0;
        for (int c = 0; c < 200 && !drain_ok; c++) begin
            rd_ready = rdy_pat[c % 4];
            if (rd_valid) begin
                if (stalled && rd_data !== held) held_diff++;
                if (rd_ready) begin
                    got_q.push_back(rd_data); last_q.push_back(rd_last);
                    stalled = 0;
                    if (rd_last) drain_ok = 1;
                end else begin
                    held = rd_data; stalled = 1;
                end
            end
            @(negedge CLK);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++; if ({busy, rd_valid, rd_last, triggered} !== 4'b0 || cyc_cnt !== 0 || rd_data !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b valid=%b last=%b trig=%b cyc=%0d data=%h want all 0",
                             busy, rd_valid, rd_last, triggered, cyc_cnt, rd_data); end
        start(32'd2, 32'hFFFF_FFFF, 4'd10);
        total++; if (busy !== 1'b1 || cyc_cnt !== 32'd0) begin
            bad++; $display("FAIL armed_state got busy=%b cyc=%0d want busy=1 cyc=0", busy, cyc_cnt); end
        feed(0, 5);
        total++; if (triggered !== 1'b1) begin
            bad++; $display("FAIL post_triggered got %b want 1", triggered); end
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rd_valid !== 1'b0 || triggered !== 1'b0 || cyc_cnt !== 32'd0) begin
            bad++; $display("FAIL async_reset got busy=%b valid=%b trig=%b cyc=%0d want 0 0 0 0",
                             busy, rd_valid, triggered, cyc_cnt); end
        @(negedge CLK);
        rst = 1'b1;
    endtask

    task automatic test_no_wrap;
        start(32'd10, 32'hFFFF_FFFF, 4'd3);
        feed(0, 40);
        total++; if (rd_valid !== 1'b1 || triggered !== 1'b1 || cyc_cnt !== 32'd41) begin
            bad++; $display("FAIL nowrap_done got valid=%b trig=%b cyc=%0d want 1 1 41", rd_valid, triggered, cyc_cnt); end
        drain(4'b1111);
        total++; if (!drain_ok || got_q.size() != 14) begin
            bad++; $display("FAIL nowrap_count got %0d want 14", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            total++; if (got_q[k] !== pat(k) || last_q[k] !== (k == 13)) begin
                bad++; $display("FAIL nowrap_entry[%0d] got %h last=%b want %h last=%b", k, got_q[k], last_q[k], pat(k), k == 13); end
        end
        total++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL nowrap_idle got busy=%b valid=%b want 0 0", busy, rd_valid); end
    endtask

    task automatic test_wrap;
        start(32'd30, 32'hFFFF_FFFF, 4'd3);
        feed(0, 40);
        total++; if (triggered !== 1'b1) begin
            bad++; $display("FAIL wrap_triggered got %b want 1", triggered); end
        drain(4'b1111);
        total++; if (!drain_ok || got_q.size() != 16) begin
            bad++; $display("FAIL wrap_count got %0d want 16", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            total++; if (got_q[k] !== pat(18 + k) || last_q[k] !== (k == 15)) begin
                bad++; $display("FAIL wrap_entry[%0d] got %h last=%b want %h last=%b", k, got_q[k], last_q[k], pat(18 + k), k == 15); end
        end
    endtask

    task automatic test_single;
        start(32'hDEAD_BEEF, 32'd0, 4'd0);
        feed(0, -1);
        @(negedge CLK);
        @(negedge CLK);
        total++; if (rd_valid !== 1'b0 || triggered !== 1'b0) begin
            bad++; $display("FAIL single_wait got valid=%b trig=%b want 0 0", rd_valid, triggered); end
        feed(5, 5);
        total++; if (rd_valid !== 1'b1 || rd_last !== 1'b1 || triggered !== 1'b1 || rd_data !== pat(5)) begin
            bad++; $display("FAIL single_entry got valid=%b last=%b trig=%b data=%h want 1 1 1 %h",
                             rd_valid, rd_last, triggered, rd_data, pat(5)); end
        drain(4'b1111);
        total++; if (!drain_ok || got_q.size() != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_drain got n=%0d busy=%b want 1 0", got_q.size(), busy); end
    endtask

    task automatic test_stall;
        start(32'd10, 32'hFFFF_FFFF, 4'd3);
        feed(0, 20);
        @(negedge CLK);
        arm = 1'b1;
        @(negedge CLK);
        arm = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== pat(0)) begin
            bad++; $display("FAIL arm_in_done got valid=%b data=%h want 1 %h", rd_valid, rd_data, pat(0)); end
        drain(4'b1001);
        total++; if (held_diff !== 0) begin
            bad++; $display("FAIL stall_stable got %0d changes want 0", held_diff); end
        total++; if (!drain_ok || got_q.size() != 14) begin
            bad++; $display("FAIL stall_count got %0d want 14", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            total++; if (got_q[k] !== pat(k)) begin
                bad++; $display("FAIL stall_entry[%0d] got %h want %h", k, got_q[k], pat(k)); end
        end
    endtask

    task automatic test_abort;
        start(32'd2, 32'hFFFF_FFFF, 4'd10);
        feed(0, 5);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        total++; if (busy !== 1'b0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL abort_post got busy=%b trig=%b valid=%b want 0 0 0", busy, triggered, rd_valid); end
        arm = 1'b1; abort = 1'b1;
        @(negedge CLK);
        arm = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL abort_beats_arm got busy=%b want 0", busy); end
    endtask

    initial begin
        rst = 1'b0; arm = 1'b0; abort = 1'b0; probe_en = 1'b0; rd_ready = 1'b0;
        probe = '0; trig_val = '0; trig_mask = '0; post_cnt = '0;
        #12;
        test_reset_pre: begin end
        rst = 1'b1;
        test_reset;
        test_no_wrap;
        test_wrap;
        test_single;
        test_stall;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
